// File: rtl/soc_ram_ctrl_if.sv
// Request/response bus between a client (CPU LSU, DMA) and soc_ram_ctrl.
// master = client side, slave = controller side.
interface soc_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_mask;
    logic [WORD_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WORD_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_mask, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_mask, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/soc_ram_ctrl.sv
// soc_ram_ctrl: single-port word-RAM initiator.
// Turns a valid/ready request stream into sel/read/write/addr/mask/data RAM
// commands. Writes are posted; reads are serialised (one in flight) and the
// response is taken straight from the RAM read port, which holds its word
// until the next read strobe.
// Optional build macro SOC_RAM_CTRL_INIT_EN: after reset the controller
// zero-fills the whole RAM before accepting requests.
module soc_ram_ctrl #(
    parameter int VECTOR_LENGTH = 256,
    parameter int WORD_WIDTH    = 16,
    parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    soc_ram_ctrl_if.slave         bus,
    output logic                  init_done_o,
    output logic                  ram_sel_o,
    output logic                  ram_read_o,
    output logic                  ram_write_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_mask_o,
    output logic [WORD_WIDTH-1:0] ram_data_o,
    input  logic [WORD_WIDTH-1:0] ram_data_i
);

`ifdef SOC_RAM_CTRL_INIT_EN
    localparam logic [1:0] ST_INIT = 2'd0;
`endif
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_RD_PEND = 2'd2;

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       req_ready_s;
    logic       accept_s;
    logic       init_done_r;

`ifdef SOC_RAM_CTRL_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(VECTOR_LENGTH - 1);
    logic [ADDR_WIDTH-1:0] init_cnt_r;
`endif

    // Request ready: free in IDLE, or in RD_PEND when the pending response is consumed now.
    always_comb begin
        req_ready_s = 1'b0;
        if (!rstn_i) begin
            req_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            req_ready_s = 1'b1;
        end else if (state_r == ST_RD_PEND) begin
            req_ready_s = bus.rsp_ready;
        end else begin
            req_ready_s = 1'b0;
        end
    end

    assign accept_s      = bus.req_valid && req_ready_s;
    assign bus.req_ready = req_ready_s;

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !bus.req_write) begin
                    state_nxt_s = ST_RD_PEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_PEND: begin
                if (accept_s) begin
                    state_nxt_s = bus.req_write ? ST_IDLE : ST_RD_PEND;
                end else if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RD_PEND;
                end
            end
`ifdef SOC_RAM_CTRL_INIT_EN
            ST_INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
`endif
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; reset drops any pending read immediately.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
`ifdef SOC_RAM_CTRL_INIT_EN
            state_r <= ST_INIT;
`else
            state_r <= ST_IDLE;
`endif
        end else begin
            state_r <= state_nxt_s;
        end
    end

`ifdef SOC_RAM_CTRL_INIT_EN
    // Zero-fill address counter, advances once per INIT cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            init_cnt_r <= '0;
        end else if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + ADDR_WIDTH'(1);
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end

    // Init-done flag, raised in the cycle after the last zero-fill write.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            init_done_r <= 1'b0;
        end else if ((state_r == ST_INIT) && (init_cnt_r == INIT_LAST)) begin
            init_done_r <= 1'b1;
        end else begin
            init_done_r <= init_done_r;
        end
    end
`else
    // Without zero-fill the controller is ready from the first edge after reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= 1'b1;
        end
    end
`endif

    assign init_done_o = init_done_r;

    // RAM command drive: zero-fill during INIT, otherwise same-cycle request pass-through.
    always_comb begin
        ram_sel_o   = 1'b0;
        ram_read_o  = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = bus.req_addr;
        ram_mask_o  = bus.req_mask;
        ram_data_o  = bus.req_data;
`ifdef SOC_RAM_CTRL_INIT_EN
        if (rstn_i && (state_r == ST_INIT)) begin
            ram_sel_o   = 1'b1;
            ram_write_o = 1'b1;
            ram_read_o  = 1'b0;
            ram_addr_o  = init_cnt_r;
            ram_mask_o  = '0;
            ram_data_o  = '0;
        end else
`endif
        if (accept_s) begin
            ram_sel_o   = 1'b1;
            ram_write_o = bus.req_write;
            ram_read_o  = !bus.req_write;
        end else begin
            ram_sel_o   = 1'b0;
            ram_write_o = 1'b0;
            ram_read_o  = 1'b0;
        end
    end

    // Response channel: the RAM holds its read word, so it is forwarded directly.
    always_comb begin
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        if (state_r == ST_RD_PEND) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = ram_data_i;
        end else begin
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = '0;
        end
    end

endmodule

// File: tb/tb_soc_ram_ctrl.sv
// Testbench for soc_ram_ctrl: directed vector table, reset-in-flight
// sequence, and randomized traffic against a transaction-level model.
module tb_soc_ram_ctrl;

    localparam int VL = 256;
    localparam int WW = 16;
    localparam int AW = 8;

    logic          clk;
    logic          rstn;
    logic          init_done;
    logic          ram_sel;
    logic          ram_read;
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_mask;
    logic [WW-1:0] ram_wdata;
    logic [WW-1:0] ram_rdata = 16'h0000;

    soc_ram_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    soc_ram_ctrl #(.VECTOR_LENGTH(VL), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .bus         (bus),
        .init_done_o (init_done),
        .ram_sel_o   (ram_sel),
        .ram_read_o  (ram_read),
        .ram_write_o (ram_write),
        .ram_addr_o  (ram_addr),
        .ram_mask_o  (ram_mask),
        .ram_data_o  (ram_wdata),
        .ram_data_i  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural word RAM: masked write, registered read held until next read.
    logic [WW-1:0] ram_mem [VL] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (ram_sel && ram_write) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ram_mask) | (ram_wdata & ~ram_mask);
        if (ram_sel && ram_read)  ram_rdata <= ram_mem[ram_addr];
    end

    // Transaction-level reference: memory contents plus the one outstanding read.
    logic [WW-1:0] ref_mem [VL] = '{default: 16'h0000};
    bit            pend;
    logic [WW-1:0] pend_data;

    int tests;
    int fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then let it settle.
    task automatic apply(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [WW-1:0] m, input logic [WW-1:0] d, input logic rr);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_mask  = m;
        bus.req_data  = d;
        bus.rsp_ready = rr;
        #1;
    endtask

    // Compare DUT against the reference for the current cycle, then advance the reference.
    task automatic model_check();
        logic exp_ready;
        logic exp_acc;
        exp_ready = !pend || bus.rsp_ready;
        exp_acc   = bus.req_valid && exp_ready;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(pend));
        check("rsp_data",  32'(bus.rsp_data),  pend ? 32'(pend_data) : 32'h0);
        check("ram_sel",   32'(ram_sel),   32'(exp_acc));
        check("ram_read",  32'(ram_read),  32'(exp_acc && !bus.req_write));
        check("ram_write", 32'(ram_write), 32'(exp_acc && bus.req_write));
        check("ram_addr",  32'(ram_addr),  32'(bus.req_addr));
        check("ram_mask",  32'(ram_mask),  32'(bus.req_mask));
        check("ram_data",  32'(ram_wdata), 32'(bus.req_data));
        if (exp_acc && bus.req_write)
            ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & bus.req_mask) | (bus.req_data & ~bus.req_mask);
        if (exp_acc && !bus.req_write) begin
            pend      = 1'b1;
            pend_data = ref_mem[bus.req_addr];
        end else if (bus.rsp_ready) begin
            pend = 1'b0;
        end
    endtask

    // Called with rstn just released at a falling edge: checks start-up behaviour.
    task automatic post_reset();
        pend = 1'b0;
`ifdef SOC_RAM_CTRL_INIT_EN
        for (int i = 0; i < VL; i++) begin
            #1;
            check("init_strobe", {ram_sel, ram_write, ram_read, bus.req_ready, init_done},
                  {27'h0, 5'b11000});
            check("init_addr", 32'(ram_addr), 32'(i));
            check("init_md",   {ram_mask, ram_wdata}, 32'h0);
            @(negedge clk);
        end
        #1;
        check("init_done_after", 32'(init_done), 32'h1);
        check("ready_after_init", 32'(bus.req_ready), 32'h1);
        for (int i = 0; i < VL; i++) ref_mem[i] = 16'h0000;
`else
        #1;
        check("ready_first_cycle", 32'(bus.req_ready), 32'h1);
        check("init_done_pre_edge", 32'(init_done), 32'h0);
        @(posedge clk);
        #1;
        check("init_done_post_edge", 32'(init_done), 32'h1);
`endif
    endtask

    typedef struct {
        logic          v;
        logic          w;
        logic [AW-1:0] a;
        logic [WW-1:0] m;
        logic [WW-1:0] d;
        logic          rr;
        logic          e_ready;
        logic          e_rv;
        logic [WW-1:0] e_rd;
        logic          e_sel;
    } vec_t;

    function automatic vec_t mk(logic v, logic w, logic [AW-1:0] a, logic [WW-1:0] m, logic [WW-1:0] d,
                                logic rr, logic e_ready, logic e_rv, logic [WW-1:0] e_rd, logic e_sel);
        vec_t t;
        t.v = v; t.w = w; t.a = a; t.m = m; t.d = d; t.rr = rr;
        t.e_ready = e_ready; t.e_rv = e_rv; t.e_rd = e_rd; t.e_sel = e_sel;
        return t;
    endfunction

    vec_t tbl [24];

    initial begin
        tests = 0;
        fails = 0;
        pend  = 1'b0;
        pend_data = 16'h0000;

        //           v     w     addr   mask      data      rr    rdy   rv    rd        sel
        tbl[0]  = mk(1'b1, 1'b1, 8'h10, 16'h0000, 16'hA5A5, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[1]  = mk(1'b1, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[2]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA5A5, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 8'h20, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[4]  = mk(1'b1, 1'b1, 8'h20, 16'hFF00, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[5]  = mk(1'b1, 1'b0, 8'h20, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFF34, 1'b0);
        tbl[7]  = mk(1'b1, 1'b1, 8'h01, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[8]  = mk(1'b1, 1'b1, 8'h02, 16'h0000, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[9]  = mk(1'b1, 1'b1, 8'h03, 16'h0000, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[10] = mk(1'b1, 1'b1, 8'h05, 16'h0000, 16'h5555, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 8'h01, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[12] = mk(1'b1, 1'b0, 8'h02, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1);
        tbl[13] = mk(1'b1, 1'b0, 8'h03, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0);
        tbl[15] = mk(1'b1, 1'b0, 8'h05, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[16] = mk(1'b1, 1'b1, 8'h06, 16'h0000, 16'h0BAD, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        tbl[17] = mk(1'b1, 1'b1, 8'h06, 16'h0000, 16'h0BAD, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        tbl[18] = mk(1'b1, 1'b1, 8'h06, 16'h0000, 16'h0BAD, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        tbl[19] = mk(1'b1, 1'b1, 8'h06, 16'h0000, 16'h0BAD, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        tbl[20] = mk(1'b1, 1'b1, 8'h06, 16'h0000, 16'h0BAD, 1'b1, 1'b1, 1'b1, 16'h5555, 1'b1);
        tbl[21] = mk(1'b1, 1'b0, 8'h06, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        tbl[22] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0BAD, 1'b0);
        tbl[23] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Reset state.
        rstn          = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_mask  = 16'h0000;
        bus.req_data  = 16'h0000;
        bus.rsp_ready = 1'b1;
        #2;
        check("rst_outputs", {bus.req_ready, bus.rsp_valid, ram_sel, ram_read, ram_write, init_done},
              32'h0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        post_reset();

        // Directed vector table.
        for (int i = 0; i < 24; i++) begin
            apply(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].d, tbl[i].rr);
            model_check();
            check($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_ready));
            check($sformatf("vec%0d_rv", i),    32'(bus.rsp_valid), 32'(tbl[i].e_rv));
            check($sformatf("vec%0d_rd", i),    32'(bus.rsp_data),  32'(tbl[i].e_rd));
            check($sformatf("vec%0d_sel", i),   32'(ram_sel),       32'(tbl[i].e_sel));
        end

        // Reset pulsed while a read response is pending.
        apply(1'b1, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b0);
        model_check();
        apply(1'b1, 1'b1, 8'h11, 16'h0000, 16'h7777, 1'b0);
        check("rd_pend_before_rst", {bus.rsp_valid, bus.rsp_data}, {15'h0, 1'b1, 16'hA5A5});
        #2;
        rstn = 1'b0;
        #1;
        check("rst_drops_rsp", {bus.rsp_valid, bus.rsp_data}, 32'h0);
        check("rst_forces_off", {bus.req_ready, ram_sel, ram_read, ram_write}, 32'h0);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        post_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1);
            model_check();
            check("no_rsp_after_rst", 32'(bus.rsp_valid), 32'h0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            apply($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  WW'($urandom), WW'($urandom), $urandom_range(0, 3) != 0);
            model_check();
        end

        apply(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
